// File: rtl/fix_mac_accum.sv
// Signed fixed-point multiply-accumulate over packets, with a round/saturate result per packet.
// Latency: last beat accepted at edge t -> out_valid=1 after edge t+3 (mult, accumulate, round, saturate).
// Backpressure: in_ready drops from the last beat until the result handshake; the result holds while out_ready=0.
//
// Ports:
//   sys_clk, sys_rst        : clock, synchronous active-high reset
//   in_valid/in_ready       : input beat handshake
//   in_a, in_b              : signed operands (D_W bits, FRAC_W fraction bits)
//   in_sub                  : subtract this beat's product instead of adding it
//   in_last                 : final beat of the packet
//   out_valid/out_ready     : result handshake
//   out_q                   : rounded, saturated packet result
//   out_sat                 : result clipped, or accumulator wrapped during the packet
module fix_mac_accum #(
  parameter int D_W    = 16,
  parameter int FRAC_W = 14,
  parameter int ACC_W  = 40
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D_W-1:0] in_a,
  input  logic [D_W-1:0] in_b,
  input  logic           in_sub,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] out_q,
  output logic           out_sat
);

  localparam int P_W = 2 * D_W;
  // Width of the rounded value before saturation: one guard bit above the accumulator.
  localparam int RW  = ACC_W + 1 - FRAC_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC_W - 1);

  logic [1:0]       state_q,    state_d;
  // stage 1: product and beat attributes
  logic             s1_vld_q,   s1_vld_d;
  logic [P_W-1:0]   s1_p_q,     s1_p_d;
  logic             s1_sub_q,   s1_sub_d;
  logic             s1_last_q,  s1_last_d;
  logic             s1_first_q, s1_first_d;
  // stage 2: accumulator and sticky overflow
  logic [ACC_W-1:0] acc_q,      acc_d;
  logic             ov_q,       ov_d;
  logic             s2_last_q,  s2_last_d;
  // stage 3: rounded packet value
  logic             s3_vld_q,   s3_vld_d;
  logic [RW-1:0]    s3_r_q,     s3_r_d;
  logic             s3_ov_q,    s3_ov_d;
  // output register
  logic             out_valid_q, out_valid_d;
  logic [D_W-1:0]   out_q_q,     out_q_d;
  logic             out_sat_q,   out_sat_d;

  logic                    accept;
  logic [P_W-1:0]          a_ext, b_ext, prod;
  logic [ACC_W-1:0]        base, p_ext, sum;
  logic                    add_ov;
  logic signed [ACC_W:0]   rnd;
  logic [RW-D_W:0]         r_hi;
  logic                    fits;

  always_comb begin
    state_d     = state_q;
    s1_vld_d    = 1'b0;
    s1_p_d      = s1_p_q;
    s1_sub_d    = s1_sub_q;
    s1_last_d   = s1_last_q;
    s1_first_d  = s1_first_q;
    acc_d       = acc_q;
    ov_d        = ov_q;
    s2_last_d   = 1'b0;
    s3_vld_d    = 1'b0;
    s3_r_d      = s3_r_q;
    s3_ov_d     = s3_ov_q;
    out_valid_d = out_valid_q;
    out_q_d     = out_q_q;
    out_sat_d   = out_sat_q;

    in_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    accept   = in_valid && in_ready;

    // Full-width signed product via explicit sign extension to 2*D_W.
    a_ext = {{D_W{in_a[D_W-1]}}, in_a};
    b_ext = {{D_W{in_b[D_W-1]}}, in_b};
    prod  = a_ext * b_ext;

    // The first beat of a packet starts from zero, so stale acc never leaks in.
    base  = s1_first_q ? '0 : acc_q;
    p_ext = ACC_W'($signed(s1_p_q));
    sum   = s1_sub_q ? (base - p_ext) : (base + p_ext);
    if (s1_sub_q)
      add_ov = (base[ACC_W-1] != p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    else
      add_ov = (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);

    // Round half up: one extra bit so adding the half-LSB cannot wrap.
    rnd = $signed({acc_q[ACC_W-1], acc_q}) + $signed(HALF);

    // Value fits in D_W bits when every bit from the D_W sign position up agrees.
    r_hi = s3_r_q[RW-1:D_W-1];
    fits = (&r_hi) || !(|r_hi);

    if (accept) begin
      s1_vld_d   = 1'b1;
      s1_p_d     = prod;
      s1_sub_d   = in_sub;
      s1_last_d  = in_last;
      s1_first_d = (state_q == ST_IDLE);
    end

    if (s1_vld_q) begin
      acc_d     = sum;
      ov_d      = (s1_first_q ? 1'b0 : ov_q) | add_ov;
      s2_last_d = s1_last_q;
    end

    if (s2_last_q) begin
      s3_vld_d = 1'b1;
      s3_r_d   = RW'(rnd >>> FRAC_W);
      s3_ov_d  = ov_q;
    end

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (accept)
          state_d = in_last ? ST_DRAIN : ST_ACCUM;
      end
      ST_DRAIN: begin
        if (s3_vld_q) begin
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          if (fits) begin
            out_q_d   = s3_r_q[D_W-1:0];
            out_sat_d = s3_ov_q;
          end else begin
            out_q_d   = s3_r_q[RW-1] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
            out_sat_d = 1'b1;
          end
        end
      end
      default: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      s1_vld_q    <= 1'b0;
      s1_p_q      <= '0;
      s1_sub_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_first_q  <= 1'b0;
      acc_q       <= '0;
      ov_q        <= 1'b0;
      s2_last_q   <= 1'b0;
      s3_vld_q    <= 1'b0;
      s3_r_q      <= '0;
      s3_ov_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_vld_q    <= s1_vld_d;
      s1_p_q      <= s1_p_d;
      s1_sub_q    <= s1_sub_d;
      s1_last_q   <= s1_last_d;
      s1_first_q  <= s1_first_d;
      acc_q       <= acc_d;
      ov_q        <= ov_d;
      s2_last_q   <= s2_last_d;
      s3_vld_q    <= s3_vld_d;
      s3_r_q      <= s3_r_d;
      s3_ov_q     <= s3_ov_d;
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_sat   = out_sat_q;

endmodule
